// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter slice.
// State encodings are fixed so other calculator units can decode them.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_RDY = 2'd2,
        RELEASE  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_BITS = 4;
    localparam int DEFAULT_NREQ = 2;

    // Keeps the pointer at least one bit wide.
    function automatic int ptrWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_PTR_W = ptrWidth(DEFAULT_NREQ);

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side and divider-side signals of the divider arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface div_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int NREQ = DEFAULT_NREQ
);
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] a_in;
    logic [NREQ*BITS-1:0] b_in;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [BITS-1:0]      quot;
    logic [BITS-1:0]      rem;
    logic                 err;
    logic                 busy;
    logic                 div_start;
    logic [BITS-1:0]      div_a;
    logic [BITS-1:0]      div_b;
    logic [BITS-1:0]      div_q;
    logic [BITS-1:0]      div_r;
    logic                 div_err;
    logic                 div_ready;

    modport slave (
        input  req, a_in, b_in, div_q, div_r, div_err, div_ready,
        output gnt, done, quot, rem, err, busy, div_start, div_a, div_b
    );

    modport master (
        output req, a_in, b_in, div_q, div_r, div_err, div_ready,
        input  gnt, done, quot, rem, err, busy, div_start, div_a, div_b
    );

endinterface

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin select: first set request strictly after ptr_i,
// wrapping around, so the last winner has the lowest priority.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  oneHot_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        oneHot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                oneHot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one iterative divider among NREQ requesters:
// grant, launch, wait for ready, hand back the result, release the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int NREQ = DEFAULT_NREQ
) (
    input logic          clk,
    input logic          rst,
    div_arbiter_if.slave bus
);

    localparam int PTR_W = ptrWidth(NREQ);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] lastWinner_q, lastWinner_d;
    logic [PTR_W-1:0] winner_q, winner_d;
    logic [BITS-1:0]  opA_q, opA_d, opB_q, opB_d;
    logic [BITS-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  pickOneHot;
    logic [PTR_W-1:0] pickIdx;
    logic             pickAny;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i    (bus.req),
        .ptr_i    (lastWinner_q),
        .oneHot_o (pickOneHot),
        .idx_o    (pickIdx),
        .any_o    (pickAny)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (pickAny) state_d = LAUNCH;
            LAUNCH:   state_d = WAIT_RDY;
            WAIT_RDY: if (bus.div_ready) state_d = RELEASE;
            RELEASE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The divisor is forced to 1 outside an operation so a stale zero cannot
    // push the idle divider into its done state.
    always_comb begin
        bus.gnt       = '0;
        bus.done      = '0;
        bus.div_start = 1'b0;
        bus.div_b     = BITS'(1);
        unique case (state_q)
            IDLE:     bus.gnt = pickOneHot;
            LAUNCH: begin
                bus.div_start = 1'b1;
                bus.div_b     = opB_q;
            end
            WAIT_RDY: bus.div_b = opB_q;
            RELEASE: begin
                bus.done[winner_q] = 1'b1;
                bus.div_start      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.div_a = opA_q;
    assign bus.quot  = quot_q;
    assign bus.rem   = rem_q;
    assign bus.err   = err_q;

    always_comb begin
        lastWinner_d = lastWinner_q;
        winner_d     = winner_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        err_d        = err_q;
        if (state_q == IDLE && pickAny) begin
            winner_d = pickIdx;
            opA_d    = bus.a_in[int'(pickIdx)*BITS +: BITS];
            opB_d    = bus.b_in[int'(pickIdx)*BITS +: BITS];
        end
        if (state_q == WAIT_RDY && bus.div_ready) begin
            quot_d = bus.div_q;
            rem_d  = bus.div_r;
            err_d  = bus.div_err;
        end
        if (state_q == RELEASE) begin
            lastWinner_d = winner_q;
        end
    end

    // Pointer resets to the last requester so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastWinner_q <= PTR_W'(NREQ - 1);
            winner_q     <= '0;
            opA_q        <= '0;
            opB_q        <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            lastWinner_q <= lastWinner_d;
            winner_q     <= winner_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural repeated-subtraction
// divider timing model (ready 2q+2 cycles after start, zero divisor immediate).
module tb_div_arbiter;

    localparam int BITS = 4;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus ();

    div_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {D_IDLE, D_COMP, D_DONE} div_state_e;
    div_state_e      dState;
    logic [BITS-1:0] dq, dr;
    int              dCnt;

    // Divider model: loads div_a while idle, zero divisor jumps to done,
    // start while done returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dState <= D_IDLE;
            dq     <= '0;
            dr     <= '0;
            dCnt   <= 0;
        end else begin
            case (dState)
                D_IDLE: begin
                    dq <= '0;
                    dr <= bus.div_a;
                    if (bus.div_b == 0) begin
                        dState <= D_DONE;
                    end else if (bus.div_start) begin
                        dState <= D_COMP;
                        dq     <= bus.div_a / bus.div_b;
                        dr     <= bus.div_a % bus.div_b;
                        dCnt   <= 2 * int'(bus.div_a / bus.div_b);
                    end
                end
                D_COMP: begin
                    if (dCnt == 0) dState <= D_DONE;
                    else           dCnt   <= dCnt - 1;
                end
                default: begin
                    if (bus.div_start) dState <= D_IDLE;
                end
            endcase
        end
    end

    assign bus.div_q     = dq;
    assign bus.div_r     = dr;
    assign bus.div_ready = (dState == D_DONE);
    assign bus.div_err   = (bus.div_b == 0);

    typedef struct {
        logic [NREQ-1:0] req;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        int              winner;
        int              q;
        int              r;
        int              e;
        int              lat;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [BITS-1:0] a0,
                                 input logic [BITS-1:0] b0, input logic [BITS-1:0] a1,
                                 input logic [BITS-1:0] b1);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.a_in = {a1, a0};
        bus.b_in = {b1, b0};
    endtask

    task automatic dropReq(input int i);
        @(posedge clk);
        #1;
        bus.req[i] = 1'b0;
    endtask

    task automatic waitGrant(output int waited, output logic [NREQ-1:0] g);
        waited = -1;
        g      = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                waited = c;
                g      = bus.gnt;
                break;
            end
        end
    endtask

    task automatic waitDone(output int lat);
        lat = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus.done != 0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        logic [BITS-1:0] a0, b0, a1, b1;
        logic [NREQ-1:0] g;
        int              w, lat;
        if (v.winner == 0) begin
            a0 = v.a;  b0 = v.b;  a1 = ~v.a; b1 = ~v.b;
        end else begin
            a1 = v.a;  b1 = v.b;  a0 = ~v.a; b0 = ~v.b;
        end
        applyStimulus(v.req, a0, b0, a1, b1);
        waitGrant(w, g);
        checkOutput({tag, " gnt"}, int'(g), 1 << v.winner);
        checkOutput({tag, " gnt_wait"}, w, 1);
        dropReq(v.winner);
        waitDone(lat);
        checkOutput({tag, " latency"}, lat, v.lat);
        checkOutput({tag, " done"}, int'(bus.done), 1 << v.winner);
        checkOutput({tag, " quot"}, int'(bus.quot), v.q);
        checkOutput({tag, " rem"}, int'(bus.rem), v.r);
        checkOutput({tag, " err"}, int'(bus.err), v.e);
        @(negedge clk);
        checkOutput({tag, " busy_after"}, int'(bus.busy), 0);
        checkOutput({tag, " ready_in_idle"}, int'(bus.div_ready), 0);
    endtask

    // Both requesters raised together; each drops its request after its grant.
    task automatic serveBoth(input int first, input int second, input int qFirst,
                             input int qSecond, input string tag);
        logic [NREQ-1:0] g;
        int              w, lat;
        applyStimulus(2'b11, 4'd6, 4'd3, 4'd4, 4'd1);
        waitGrant(w, g);
        checkOutput({tag, " first_gnt"}, int'(g), 1 << first);
        dropReq(first);
        waitDone(lat);
        checkOutput({tag, " first_done"}, int'(bus.done), 1 << first);
        checkOutput({tag, " first_quot"}, int'(bus.quot), qFirst);
        waitGrant(w, g);
        checkOutput({tag, " second_gnt"}, int'(g), 1 << second);
        checkOutput({tag, " second_gap"}, w, 1);
        dropReq(second);
        waitDone(lat);
        checkOutput({tag, " second_done"}, int'(bus.done), 1 << second);
        checkOutput({tag, " second_quot"}, int'(bus.quot), qSecond);
        @(negedge clk);
    endtask

    initial begin
        logic [NREQ-1:0] g;
        int              w, lat, doneSeen;
        vec_t            postReset;

        vecs[0] = '{req: 2'b01, a: 4'd7,  b: 4'd2, winner: 0, q: 3,  r: 1, e: 0, lat: 10};
        vecs[1] = '{req: 2'b10, a: 4'd5,  b: 4'd0, winner: 1, q: 0,  r: 5, e: 1, lat: 3};
        vecs[2] = '{req: 2'b01, a: 4'd9,  b: 4'd3, winner: 0, q: 3,  r: 0, e: 0, lat: 10};
        vecs[3] = '{req: 2'b10, a: 4'd14, b: 4'd4, winner: 1, q: 3,  r: 2, e: 0, lat: 10};
        vecs[4] = '{req: 2'b10, a: 4'd0,  b: 4'd7, winner: 1, q: 0,  r: 0, e: 0, lat: 4};
        vecs[5] = '{req: 2'b01, a: 4'd15, b: 4'd1, winner: 0, q: 15, r: 0, e: 0, lat: 34};
        postReset = '{req: 2'b01, a: 4'd8, b: 4'd4, winner: 0, q: 2, r: 0, e: 0, lat: 8};

        rst      = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset gnt", int'(bus.gnt), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset quot", int'(bus.quot), 0);
        checkOutput("reset rem", int'(bus.rem), 0);
        checkOutput("reset err", int'(bus.err), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset div_start", int'(bus.div_start), 0);
        checkOutput("reset div_b", int'(bus.div_b), 1);

        serveBoth(0, 1, 2, 4, "fair1");

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        serveBoth(1, 0, 4, 2, "fair2");

        applyStimulus(2'b01, 4'd3, 4'd5, 4'd0, 4'd0);
        waitGrant(w, g);
        checkOutput("b2b first_gnt", int'(g), 1);
        for (int i = 0; i < 3; i++) begin
            waitDone(lat);
            checkOutput($sformatf("b2b%0d latency", i), lat, 4);
            checkOutput($sformatf("b2b%0d quot", i), int'(bus.quot), 0);
            checkOutput($sformatf("b2b%0d rem", i), int'(bus.rem), 3);
            if (i < 2) begin
                waitGrant(w, g);
                checkOutput($sformatf("b2b%0d regrant_gap", i), w, 1);
                checkOutput($sformatf("b2b%0d regrant", i), int'(g), 1);
            end else begin
                bus.req = '0;
            end
        end
        @(negedge clk);
        checkOutput("b2b idle_gnt", int'(bus.gnt), 0);
        checkOutput("b2b idle_busy", int'(bus.busy), 0);

        applyStimulus(2'b01, 4'd15, 4'd1, 4'd0, 4'd0);
        waitGrant(w, g);
        checkOutput("midrst gnt", int'(g), 1);
        dropReq(0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst busy", int'(bus.busy), 0);
        checkOutput("midrst done", int'(bus.done), 0);
        checkOutput("midrst rem", int'(bus.rem), 0);
        checkOutput("midrst div_start", int'(bus.div_start), 0);
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done != 0 || bus.busy) doneSeen++;
        end
        checkOutput("midrst no_activity", doneSeen, 0);
        runVector(postReset, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative repeated-subtraction divider among NREQ requesters in the calculator datapath.
- Samples a winner's operands, launches the divider, and waits for completion.
- Returns quotient, remainder and divide-by-zero error to the winner with a one-cycle done pulse.
- Releases the divider so it is ready for the next operation.

Parameters:
- BITS, 4, operand and result width.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  request level, one bit per requester.
- a_in  in  NREQ*BITS  dividends; requester i uses slice [i*BITS +: BITS].
- b_in  in  NREQ*BITS  divisors, same slicing as a_in.
- gnt  out  NREQ  one-hot grant pulse; operands of the winner are sampled on this edge.
- done  out  NREQ  one-hot result-valid pulse.
- quot  out  BITS  quotient, valid with done and held until the next done.
- rem  out  BITS  remainder, valid with done and held until the next done.
- err  out  1  divide-by-zero flag, valid with done and held until the next done.
- busy  out  1  high in every state except IDLE.
- div_start  out  1  divider start/release strobe.
- div_a  out  BITS  divider dividend.
- div_b  out  BITS  divider divisor.
- div_q  in  BITS  divider quotient.
- div_r  in  BITS  divider remainder.
- div_err  in  1  divider error; combinational on div_b==0.
- div_ready  in  1  divider done; level, held until released.

Behaviour:
- Divider contract:
  - In its idle state it loads div_a every cycle.
  - If div_b==0 it goes to done unconditionally. Otherwise div_start moves it to compute.
  - div_ready rises 2q+2 cycles after start, where q is the quotient.
  - div_start while div_ready returns it to idle.
  - Operands must stay stable from launch to ready.
- Reset values: gnt=0, done=0, quot=0, rem=0, err=0, busy=0, div_start=0. State=IDLE. RR pointer selects requester 0 first.
- FSM states: IDLE, LAUNCH, WAIT_RDY, RELEASE.
- IDLE:
  - If any req bit is high: pick the first set bit at or after (last_winner+1) mod NREQ.
  - Assert gnt[winner] in that same cycle.
  - At the edge: register the winner's a and b, record winner index, move to LAUNCH.
  - If no req bit is high: stay in IDLE.
- LAUNCH: div_start=1 for one cycle, then go to WAIT_RDY.
- WAIT_RDY:
  - Wait for div_ready=1. No timeout.
  - On that edge capture div_q, div_r, div_err into quot, rem, err.
  - Go to RELEASE.
- RELEASE:
  - done[winner]=1 and div_start=1 for one cycle.
  - Update the RR pointer to the winner, then go to IDLE.
- div_a = operand register at all times.
- div_b = operand register in LAUNCH and WAIT_RDY; forced to 1 in IDLE and RELEASE. This prevents a stale zero divisor from sending an idle divider to done spuriously.
- Latency, grant cycle = 0:
  - b≠0: done at cycle 2q+4.
  - b=0: done at cycle 3, with quot=0, rem=a, err=1.
  - Next grant possible at done+1.
- req is sampled only in IDLE. A requester still holding req in IDLE after its done is treated as a new request.
- Requests arriving while busy wait in line; nothing is dropped.
- Simultaneous requests: only one gnt per IDLE visit; the others keep req high.
- div_ready seen outside WAIT_RDY is ignored.
- Reset mid-operation (any state): on the next cycle all outputs take reset values and no done is issued. The divider shares rst and also returns to idle. The pending operation is lost.
- Arithmetic is unsigned; widths are exact, with no overflow possible.

Decomposition:
- Package div_arb_pkg: state encodings IDLE=0, LAUNCH=1, WAIT_RDY=2, RELEASE=3; default BITS and NREQ; width constant $clog2(NREQ) for the pointer.
- Sub-module rr_picker: combinational round-robin priority select. Inputs are req and the pointer; outputs are a one-hot vector and an index. Reusable for other shared calculator units.

Test Plan:
- Single request, with the divider instance attached.
  - Stimulus: req[0], a=7, b=2.
  - Response: gnt[0] at cycle 0, done[0] at cycle 10, quot=3, rem=1, err=0.
- Zero divisor, then a normal operation.
  - Stimulus: req[1], a=5, b=0.
  - Response: done[1] at cycle 3, err=1, quot=0, rem=5.
  - Follow-up: req[0], a=9, b=3 → quot=3, rem=0, err=0. No div_ready while the arbiter is in IDLE.
- Fairness.
  - Stimulus: req[0] and req[1] both high from reset, each dropped after its gnt.
  - Response: service order is 0 then 1.
  - Stimulus: both raised again.
  - Response: service order is 1 then 0.
- Back-to-back service.
  - Stimulus: req[0] held high continuously, a=3, b=5.
  - Response: each done at cycle 4 relative to its gnt, quot=0, rem=3. Exactly one IDLE cycle (the next gnt) between successive dones.
- Extremes.
  - Stimulus: a=15, b=1.
  - Response: done at cycle 34, quot=15, rem=0.
- Reset mid-operation.
  - Stimulus: rst pulsed while in WAIT_RDY.
  - Response: busy=0 and no done; a new request a=8, b=4 completes with quot=2, rem=0.
